// File: rtl/mcu_bus_tx.sv
// Return-path transmitter: buffers internal response words and presents them to the MCU,
// one word per read strobe. Optional underflow counter: MCU_BUS_TX_UNDERFLOW_COUNTER_EN.
module mcu_bus_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               system_clock,
  input  logic                               system_reset_n,
  input  logic                               bus_clock,
  input  logic                               bus_read_enable,
  input  logic [DATA_WIDTH-1:0]              tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  input  logic                               tx_flush,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    tx_level,
  output logic [DATA_WIDTH-1:0]              signal_output,
  output logic                               signal_command_data_output,
  output logic [7:0]                         underflow_count
);

  localparam int PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LvlW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {EMPTY, LOADED} state_t;

  logic                  clk_s1_q, clk_s2_q, clk_s3_q;
  logic                  rden_s1_q, rden_s2_q;
  logic                  read_edge;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       count_q;
  logic                  fifo_nempty, push, pop;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;

  // Bring the asynchronous MCU strobe and direction select into the system clock domain.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
      clk_s3_q  <= 1'b0;
      rden_s1_q <= 1'b0;
      rden_s2_q <= 1'b0;
    end else begin
      clk_s1_q  <= bus_clock;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      rden_s1_q <= bus_read_enable;
      rden_s2_q <= rden_s1_q;
    end
  end

  assign read_edge   = clk_s2_q && !clk_s3_q && rden_s2_q;
  assign fifo_nempty = (count_q != '0);
  assign tx_ready    = (count_q != LvlW'(FIFO_DEPTH));
  assign push        = tx_valid && tx_ready && !tx_flush;
  assign tx_level    = count_q;

  always_ff @(posedge system_clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (tx_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + LvlW'(1);
      else if (pop && !push) count_q <= count_q - LvlW'(1);
    end
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // The output register is refilled from the FIFO head in the same cycle it is consumed.
  always_comb begin
    state_d                    = state_q;
    out_d                      = out_q;
    pop                        = 1'b0;
    signal_command_data_output = (state_q == LOADED);
    if (tx_flush) begin
      state_d = EMPTY;
      out_d   = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (fifo_nempty) begin
            pop     = 1'b1;
            out_d   = mem_q[rd_ptr_q];
            state_d = LOADED;
          end
        end
        LOADED: begin
          if (read_edge) begin
            if (fifo_nempty) begin
              pop   = 1'b1;
              out_d = mem_q[rd_ptr_q];
            end else begin
              out_d   = '0;
              state_d = EMPTY;
            end
          end
        end
        default: begin
          state_d = EMPTY;
          out_d   = '0;
        end
      endcase
    end
  end

  assign signal_output = out_q;

`ifdef MCU_BUS_TX_UNDERFLOW_COUNTER_EN
  logic [7:0] uflow_q;

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      uflow_q <= '0;
    end else if (tx_flush) begin
      uflow_q <= '0;
    end else if (state_q == EMPTY && read_edge && uflow_q != 8'hFF) begin
      uflow_q <= uflow_q + 8'd1;
    end
  end

  assign underflow_count = uflow_q;
`else
  assign underflow_count = 8'd0;
`endif

endmodule

// File: tb/tb_mcu_bus_tx.sv
// Directed self-checking bench for mcu_bus_tx with hand-computed expectations.
module tb_mcu_bus_tx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          system_clock = 1'b0;
  logic          system_reset_n = 1'b0;
  logic          bus_clock = 1'b0;
  logic          bus_read_enable = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx_flush = 1'b0;
  logic [LW-1:0] tx_level;
  logic [DW-1:0] signal_output;
  logic          signal_command_data_output;
  logic [7:0]    underflow_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] expUnderflow;

  mcu_bus_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .system_clock               (system_clock),
    .system_reset_n             (system_reset_n),
    .bus_clock                  (bus_clock),
    .bus_read_enable            (bus_read_enable),
    .tx_data                    (tx_data),
    .tx_valid                   (tx_valid),
    .tx_ready                   (tx_ready),
    .tx_flush                   (tx_flush),
    .tx_level                   (tx_level),
    .signal_output              (signal_output),
    .signal_command_data_output (signal_command_data_output),
    .underflow_count            (underflow_count)
  );

  always #5 system_clock = ~system_clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one system clock cycle of push/flush inputs; called at a negedge, returns at the next.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic valid, input logic flush);
    tx_data  = data;
    tx_valid = valid;
    tx_flush = flush;
    @(negedge system_clock);
    tx_valid = 1'b0;
    tx_flush = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge system_clock);
  endtask

  // One full MCU strobe period with direction select held for its whole duration.
  task automatic busStrobe(input logic rden);
    bus_read_enable = rden;
    idleCycles(4);
    bus_clock = 1'b1;
    idleCycles(4);
    bus_clock = 1'b0;
    idleCycles(4);
    bus_read_enable = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    idleCycles(3);
    checkOutput("reset_out",   signal_output, 0);
    checkOutput("reset_flag",  signal_command_data_output, 0);
    checkOutput("reset_level", tx_level, 0);
    checkOutput("reset_ready", tx_ready, 1);
    checkOutput("reset_uflow", underflow_count, 0);
    system_reset_n = 1'b1;
    idleCycles(2);

    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("a5_no_bypass_flag", signal_command_data_output, 0);
    checkOutput("a5_fifo_level",     tx_level, 1);
    idleCycles(1);
    checkOutput("a5_out",   signal_output, 8'hA5);
    checkOutput("a5_flag",  signal_command_data_output, 1);
    checkOutput("a5_level", tx_level, 0);
    busStrobe(1'b1);
    checkOutput("a5_read_out",   signal_output, 0);
    checkOutput("a5_read_flag",  signal_command_data_output, 0);
    checkOutput("a5_read_level", tx_level, 0);

    for (int i = 1; i <= 5; i++) applyStimulus(DW'(i), 1'b1, 1'b0);
    checkOutput("full_level", tx_level, 4);
    checkOutput("full_ready", tx_ready, 0);
    checkOutput("full_out",   signal_output, 8'h01);
    applyStimulus(8'h66, 1'b1, 1'b0);
    checkOutput("full_drop_level", tx_level, 4);
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("seq_out_%0d", i), signal_output, i);
      checkOutput($sformatf("seq_flag_%0d", i), signal_command_data_output, 1);
      busStrobe(1'b1);
      if (i == 1) begin
        checkOutput("seq_level_after_1", tx_level, 3);
        checkOutput("seq_ready_after_1", tx_ready, 1);
      end
    end
    checkOutput("seq_end_out",   signal_output, 0);
    checkOutput("seq_end_flag",  signal_command_data_output, 0);
    checkOutput("seq_end_level", tx_level, 0);

    applyStimulus(8'h3C, 1'b1, 1'b0);
    idleCycles(1);
    checkOutput("wr_pre_out", signal_output, 8'h3C);
    busStrobe(1'b0);
    busStrobe(1'b0);
    checkOutput("wr_ignored_out",  signal_output, 8'h3C);
    checkOutput("wr_ignored_flag", signal_command_data_output, 1);
    busStrobe(1'b1);
    checkOutput("wr_consumed_out", signal_output, 0);

`ifdef MCU_BUS_TX_UNDERFLOW_COUNTER_EN
    expUnderflow = 8'd3;
`else
    expUnderflow = 8'd0;
`endif
    for (int i = 0; i < 3; i++) busStrobe(1'b1);
    checkOutput("uflow_count", underflow_count, expUnderflow);
    checkOutput("uflow_out",   signal_output, 0);
    checkOutput("uflow_flag",  signal_command_data_output, 0);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("uflow_cleared", underflow_count, 0);

    applyStimulus(8'h11, 1'b1, 1'b0);
    idleCycles(1);
    applyStimulus(8'h22, 1'b1, 1'b0);
    checkOutput("flush_pre_out",   signal_output, 8'h11);
    checkOutput("flush_pre_level", tx_level, 1);
    applyStimulus(8'h33, 1'b1, 1'b1);
    checkOutput("flush_level", tx_level, 0);
    checkOutput("flush_flag",  signal_command_data_output, 0);
    checkOutput("flush_out",   signal_output, 0);
    idleCycles(3);
    checkOutput("flush_drop_out",   signal_output, 0);
    checkOutput("flush_drop_level", tx_level, 0);

    for (int i = 0; i < 4; i++) applyStimulus(DW'(8'hA1 + i), 1'b1, 1'b0);
    idleCycles(1);
    checkOutput("rst_pre_out",   signal_output, 8'hA1);
    checkOutput("rst_pre_level", tx_level, 3);
    bus_read_enable = 1'b1;
    idleCycles(4);
    bus_clock = 1'b1;
    idleCycles(1);
    #2 system_reset_n = 1'b0;
    #1;
    checkOutput("rst_async_out",   signal_output, 0);
    checkOutput("rst_async_flag",  signal_command_data_output, 0);
    checkOutput("rst_async_level", tx_level, 0);
    checkOutput("rst_async_ready", tx_ready, 1);
    bus_clock = 1'b0;
    bus_read_enable = 1'b0;
    idleCycles(2);
    system_reset_n = 1'b1;
    idleCycles(4);
    checkOutput("rst_after_out",   signal_output, 0);
    checkOutput("rst_after_flag",  signal_command_data_output, 0);
    checkOutput("rst_after_ready", tx_ready, 1);
    applyStimulus(8'hB7, 1'b1, 1'b0);
    idleCycles(1);
    checkOutput("rst_fresh_out",   signal_output, 8'hB7);
    checkOutput("rst_fresh_level", tx_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
